// File: rtl/traffic_pkg.sv
// Shared channel indexing for the intersection request logic.
package traffic_pkg;

    localparam int PED          = 0;
    localparam int UP           = 1;
    localparam int DOWN         = 2;
    localparam int TURN         = 3;
    localparam int NUM_CHANNELS = 4;

endpackage

// File: rtl/request_channel.sv
// One demand channel: synchronizer, debouncer, request latch and wait/urgency counter.
module request_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_WAIT        = 200
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic green,
    output logic request,
    output logic urgent
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic              sync_meta;
    logic              sync_out;
    logic              deb;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              deb_rise;

    // The debounced level rises on this edge; the latch sets on the same edge.
    assign deb_rise = sync_out && !deb && (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync_out == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= sync_out;
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Green always wins, so a rise arriving while the phase is being served is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            request <= 1'b0;
        end else if (green) begin
            request <= 1'b0;
        end else if (deb_rise) begin
            request <= 1'b1;
        end
    end

    // Cleared together with the request so urgent falls on the serving edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!request || green) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign urgent = (wait_cnt == WAIT_MAX);

endmodule

// File: rtl/request_latch.sv
// Latches debounced pedestrian/vehicle demand per phase until the phase is served.
module request_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_WAIT        = 200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_button,
    input  logic       up_sensor,
    input  logic       down_sensor,
    input  logic       turn_sensor,
    input  logic       pedestrian_green,
    input  logic       up_green,
    input  logic       down_green,
    input  logic       turn_green,
    output logic       pedestrian_request,
    output logic       up_request,
    output logic       down_request,
    output logic       turn_request,
    output logic [3:0] urgent,
    output logic       any_pending
);

    import traffic_pkg::*;

    logic [NUM_CHANNELS-1:0] raw_vec;
    logic [NUM_CHANNELS-1:0] green_vec;
    logic [NUM_CHANNELS-1:0] req_vec;

    assign raw_vec[PED]    = ped_button;
    assign raw_vec[UP]     = up_sensor;
    assign raw_vec[DOWN]   = down_sensor;
    assign raw_vec[TURN]   = turn_sensor;

    assign green_vec[PED]  = pedestrian_green;
    assign green_vec[UP]   = up_green;
    assign green_vec[DOWN] = down_green;
    assign green_vec[TURN] = turn_green;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
        request_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .MAX_WAIT        (MAX_WAIT)
        ) u_channel (
            .clock   (clock),
            .reset   (reset),
            .raw     (raw_vec[i]),
            .green   (green_vec[i]),
            .request (req_vec[i]),
            .urgent  (urgent[i])
        );
    end

    assign pedestrian_request = req_vec[PED];
    assign up_request         = req_vec[UP];
    assign down_request       = req_vec[DOWN];
    assign turn_request       = req_vec[TURN];
    assign any_pending        = |req_vec;

endmodule

// File: tb/tb_request_latch.sv
// Directed bench for request_latch with DEBOUNCE_CYCLES=4 and MAX_WAIT=5.
module tb_request_latch;

    logic       clock;
    logic       reset;
    logic       ped_button, up_sensor, down_sensor, turn_sensor;
    logic       pedestrian_green, up_green, down_green, turn_green;
    logic       pedestrian_request, up_request, down_request, turn_request;
    logic [3:0] urgent;
    logic       any_pending;

    int total = 0;
    int bad   = 0;
    int edge_num = 0;

    request_latch #(
        .DEBOUNCE_CYCLES (4),
        .MAX_WAIT        (5)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .ped_button         (ped_button),
        .up_sensor          (up_sensor),
        .down_sensor        (down_sensor),
        .turn_sensor        (turn_sensor),
        .pedestrian_green   (pedestrian_green),
        .up_green           (up_green),
        .down_green         (down_green),
        .turn_green         (turn_green),
        .pedestrian_request (pedestrian_request),
        .up_request         (up_request),
        .down_request       (down_request),
        .turn_request       (turn_request),
        .urgent             (urgent),
        .any_pending        (any_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        edge_num++;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_num, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] exp_req, input logic [3:0] exp_urg);
        check_output({tag, "_req"}, {28'd0, turn_request, down_request, up_request, pedestrian_request},
                     {28'd0, exp_req});
        check_output({tag, "_urgent"}, {28'd0, urgent}, {28'd0, exp_urg});
        check_output({tag, "_any"}, {31'd0, any_pending}, {31'd0, |exp_req});
    endtask

    initial begin
        logic [3:0] exp_req;
        logic [3:0] exp_urg;

        reset = 1'b0;
        {ped_button, up_sensor, down_sensor, turn_sensor} = 4'b0;
        {pedestrian_green, up_green, down_green, turn_green} = 4'b0;

        tick();
        check_all("reset_hold", 4'b0000, 4'b0000);
        tick();
        reset = 1'b1;

        while (edge_num < 9) tick();
        up_sensor = 1'b1;

        // Edges 10..40: up, down, ped and turn scenarios overlapping in time.
        while (edge_num < 40) begin
            tick();
            case (edge_num)
                14: down_sensor = 1'b1;
                15: begin up_sensor = 1'b0; up_green = 1'b1; end
                16: up_green = 1'b0;
                20: ped_button = 1'b1;
                21: down_sensor = 1'b0;
                22: ped_button = 1'b0;
                29: begin down_green = 1'b1; turn_sensor = 1'b1; end
                30: down_green = 1'b0;
                35: turn_sensor = 1'b0;
                39: turn_green = 1'b1;
                default: ;
            endcase
            exp_req = 4'b0000;
            exp_req[1] = (edge_num == 15);
            exp_req[2] = (edge_num >= 20 && edge_num <= 29);
            exp_req[3] = (edge_num >= 35 && edge_num <= 39);
            exp_urg = (edge_num >= 25 && edge_num <= 29) ? 4'b0100 : 4'b0000;
            check_all($sformatf("seq_e%0d", edge_num), exp_req, exp_urg);
        end
        turn_green = 1'b0;

        // Debounced rise of up coincides with up_green at edge 50.
        while (edge_num < 44) tick();
        up_sensor = 1'b1;
        while (edge_num < 49) tick();
        check_all("coincide_pre", 4'b0000, 4'b0000);
        up_green = 1'b1;
        tick();
        check_all("coincide_e50", 4'b0000, 4'b0000);
        up_green = 1'b0;
        tick();
        check_all("coincide_e51", 4'b0000, 4'b0000);
        up_sensor = 1'b0;

        // All four sensors rise together, sampled first at edge 60.
        while (edge_num < 59) tick();
        {ped_button, up_sensor, down_sensor, turn_sensor} = 4'b1111;
        while (edge_num < 64) tick();
        check_all("all_e64", 4'b0000, 4'b0000);
        tick();
        check_all("all_e65", 4'b1111, 4'b0000);
        tick();
        reset = 1'b0;
        #1;
        check_all("async_reset", 4'b0000, 4'b0000);
        tick();
        check_all("reset_e67", 4'b0000, 4'b0000);
        reset = 1'b1;

        while (edge_num < 72) tick();
        check_all("rereq_e72", 4'b0000, 4'b0000);
        tick();
        check_all("rereq_e73", 4'b1111, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
